// File: rtl/cabin_cmd_pkg.sv
// cabin_cmd_pkg: shared channel state type, default timing constants and width helper.
package cabin_cmd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_GAP} chan_state_e;
  localparam int DEF_HIGH_CYCLES = 4;
  localparam int DEF_LOW_CYCLES  = 4;
  localparam int DEF_MAX_PENDING = 3;
  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/cmd_channel_fsm.sv
// cmd_channel_fsm: one command channel; queues requests and emits spaced pulses.
module cmd_channel_fsm
  import cabin_cmd_pkg::*;
#(
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int LOW_CYCLES  = DEF_LOW_CYCLES,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic inhibit_i,
  input  logic clear_overflow_i,
  output logic cmd_o,
  output logic busy_o,
  output logic overflow_o
);
  localparam int TW = bits_for((HIGH_CYCLES > LOW_CYCLES ? HIGH_CYCLES : LOW_CYCLES) - 1);
  localparam int PW = bits_for(MAX_PENDING);
  chan_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic [PW-1:0] pending_q, pending_d;
  logic          cmd_q, overflow_q, overflow_d;
  logic          launch, inc, drop;
  // Launch looks only at registered pending, so a fresh request always waits one cycle in the queue.
  always_comb begin
    launch = (state_q == ST_IDLE) && (pending_q != '0) && !inhibit_i;
    inc = req_i && ((pending_q < PW'(MAX_PENDING)) || launch);
    drop = req_i && !inc;
    pending_d = pending_q + PW'(inc) - PW'(launch);
    overflow_d = (overflow_q && !clear_overflow_i) || drop;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pending_q <= '0;
      cmd_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overflow_q <= overflow_d;
      case (state_q)
        ST_IDLE: if (launch) begin
          state_q <= ST_HIGH;
          timer_q <= TW'(HIGH_CYCLES - 1);
          cmd_q <= 1'b1;
        end
        ST_HIGH: if (timer_q == '0) begin
          state_q <= ST_GAP;
          timer_q <= TW'(LOW_CYCLES - 1);
          cmd_q <= 1'b0;
        end else timer_q <= timer_q - TW'(1);
        ST_GAP: if (timer_q == '0) state_q <= ST_IDLE;
        else timer_q <= timer_q - TW'(1);
        default: begin
          state_q <= ST_IDLE;
          cmd_q <= 1'b0;
        end
      endcase
    end
  end
  assign cmd_o = cmd_q;
  assign busy_o = (state_q != ST_IDLE) || (pending_q != '0);
  assign overflow_o = overflow_q;
endmodule

// File: rtl/command_emitter.sv
// command_emitter: two independent cabin command channels (seatbelt, lighting).
module command_emitter
  import cabin_cmd_pkg::*;
#(
  parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
  parameter int LOW_CYCLES  = DEF_LOW_CYCLES,
  parameter int MAX_PENDING = DEF_MAX_PENDING
) (
  input  logic clk,
  input  logic reset,
  input  logic seatbelt_req,
  input  logic lighting_req,
  input  logic inhibit,
  input  logic clear_overflow,
  output logic seatbelt_cmd,
  output logic lighting_cmd,
  output logic seatbelt_busy,
  output logic lighting_busy,
  output logic seatbelt_overflow,
  output logic lighting_overflow
);
  cmd_channel_fsm #(.HIGH_CYCLES(HIGH_CYCLES), .LOW_CYCLES(LOW_CYCLES), .MAX_PENDING(MAX_PENDING)) u_seatbelt (
    .clk(clk), .reset(reset), .req_i(seatbelt_req), .inhibit_i(inhibit),
    .clear_overflow_i(clear_overflow), .cmd_o(seatbelt_cmd), .busy_o(seatbelt_busy),
    .overflow_o(seatbelt_overflow)
  );
  cmd_channel_fsm #(.HIGH_CYCLES(HIGH_CYCLES), .LOW_CYCLES(LOW_CYCLES), .MAX_PENDING(MAX_PENDING)) u_lighting (
    .clk(clk), .reset(reset), .req_i(lighting_req), .inhibit_i(inhibit),
    .clear_overflow_i(clear_overflow), .cmd_o(lighting_cmd), .busy_o(lighting_busy),
    .overflow_o(lighting_overflow)
  );
endmodule

// File: tb/tb_command_emitter.sv
// tb_command_emitter: directed plus random stimulus checked against a timeline model.
module tb_command_emitter;
  localparam int H = 4;
  localparam int L = 4;
  localparam int M = 3;
  logic clk = 1'b0;
  logic reset, seatbelt_req, lighting_req, inhibit, clear_overflow;
  logic seatbelt_cmd, lighting_cmd, seatbelt_busy, lighting_busy, seatbelt_overflow, lighting_overflow;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int base = 0;
  int pend[2], idle_from[2], pstart[2];
  bit ovf[2];
  int edges[2];
  logic prev_cmd[2];
  command_emitter #(.HIGH_CYCLES(H), .LOW_CYCLES(L), .MAX_PENDING(M)) dut (
    .clk(clk), .reset(reset), .seatbelt_req(seatbelt_req), .lighting_req(lighting_req),
    .inhibit(inhibit), .clear_overflow(clear_overflow), .seatbelt_cmd(seatbelt_cmd),
    .lighting_cmd(lighting_cmd), .seatbelt_busy(seatbelt_busy), .lighting_busy(lighting_busy),
    .seatbelt_overflow(seatbelt_overflow), .lighting_overflow(lighting_overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc - base, got, exp);
    end
  endtask
  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc - base, got, exp);
    end
  endtask
  // Drives one cycle, advances the pulse-timeline model, then checks every output.
  task automatic step(input logic sb, input logic lt, input logic inh, input logic clr, input logic rst);
    logic req[2];
    logic got_cmd[2], got_busy[2], got_ovf[2];
    bit launch, acc;
    req[0] = sb;
    req[1] = lt;
    seatbelt_req = sb;
    lighting_req = lt;
    inhibit = inh;
    clear_overflow = clr;
    reset = rst;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        pend[c] = 0;
        idle_from[c] = 0;
        pstart[c] = -1000;
        ovf[c] = 0;
      end else begin
        launch = (cyc >= idle_from[c]) && (pend[c] > 0) && !inh;
        if (launch) begin
          pstart[c] = cyc + 1;
          idle_from[c] = cyc + 1 + H + L;
        end
        acc = req[c] && (pend[c] < M || launch);
        ovf[c] = (ovf[c] && !clr) || (req[c] && !acc);
        pend[c] = pend[c] + int'(acc) - int'(launch);
      end
    end
    cyc++;
    #1;
    got_cmd[0] = seatbelt_cmd;
    got_cmd[1] = lighting_cmd;
    got_busy[0] = seatbelt_busy;
    got_busy[1] = lighting_busy;
    got_ovf[0] = seatbelt_overflow;
    got_ovf[1] = lighting_overflow;
    for (int c = 0; c < 2; c++) begin
      chk(c == 0 ? "sb_cmd" : "lt_cmd", got_cmd[c], (cyc >= pstart[c]) && (cyc < pstart[c] + H));
      chk(c == 0 ? "sb_busy" : "lt_busy", got_busy[c], (cyc < idle_from[c]) || (pend[c] > 0));
      chk(c == 0 ? "sb_ovf" : "lt_ovf", got_ovf[c], ovf[c]);
      if (got_cmd[c] && !prev_cmd[c]) edges[c]++;
      prev_cmd[c] = got_cmd[c];
    end
  endtask
  task automatic restart();
    step(0, 0, 0, 0, 1);
    base = cyc;
    edges[0] = 0;
    edges[1] = 0;
  endtask
  task automatic idle_to(input int t, input logic inh);
    while (cyc < base + t) step(0, 0, inh, 0, 0);
  endtask
  initial begin
    logic inh_r;
    prev_cmd[0] = 1'b0;
    prev_cmd[1] = 1'b0;
    restart();
    chk("rst_sb_cmd", seatbelt_cmd, 1'b0);
    chk("rst_lt_busy", lighting_busy, 1'b0);
    idle_to(10, 0);
    step(1, 0, 0, 0, 0);
    chk("single_k1", seatbelt_cmd, 1'b0);
    idle_to(12, 0);
    chk("single_rise", seatbelt_cmd, 1'b1);
    idle_to(15, 0);
    chk("single_last_high", seatbelt_cmd, 1'b1);
    idle_to(16, 0);
    chk("single_fall", seatbelt_cmd, 1'b0);
    idle_to(19, 0);
    chk("single_busy19", seatbelt_busy, 1'b1);
    idle_to(20, 0);
    chk("single_busy20", seatbelt_busy, 1'b0);
    chk("single_lt_quiet", lighting_cmd, 1'b0);
    restart();
    idle_to(10, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle_to(20, 0);
    chk("three_gap20", seatbelt_cmd, 1'b0);
    idle_to(21, 0);
    chk("three_rise21", seatbelt_cmd, 1'b1);
    idle_to(29, 0);
    chk("three_gap29", seatbelt_cmd, 1'b0);
    idle_to(30, 0);
    chk("three_rise30", seatbelt_cmd, 1'b1);
    idle_to(45, 0);
    chk_int("three_edges", edges[0], 3);
    chk("three_no_ovf", seatbelt_overflow, 1'b0);
    restart();
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
    chk("ovf_set", lighting_overflow, 1'b1);
    chk("ovf_sb_clean", seatbelt_overflow, 1'b0);
    idle_to(45, 0);
    chk_int("ovf_edges", edges[1], 3);
    step(0, 0, 0, 1, 0);
    chk("ovf_cleared", lighting_overflow, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    chk("ovf_set_wins", lighting_overflow, 1'b1);
    restart();
    idle_to(5, 0);
    step(1, 1, 0, 0, 0);
    idle_to(7, 0);
    chk("sim_sb_rise", seatbelt_cmd, 1'b1);
    chk("sim_lt_rise", lighting_cmd, 1'b1);
    idle_to(11, 0);
    chk("sim_sb_fall", seatbelt_cmd, 1'b0);
    chk("sim_lt_fall", lighting_cmd, 1'b0);
    restart();
    idle_to(10, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("midrst_high", seatbelt_cmd, 1'b1);
    step(0, 0, 0, 0, 1);
    chk("midrst_cmd", seatbelt_cmd, 1'b0);
    chk("midrst_busy", seatbelt_busy, 1'b0);
    base = cyc;
    edges[0] = 0;
    idle_to(30, 0);
    chk_int("midrst_edges", edges[0], 0);
    restart();
    idle_to(10, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle_to(13, 0);
    idle_to(30, 1);
    chk_int("inh_first_only", edges[0], 1);
    chk("inh_busy_waiting", seatbelt_busy, 1'b1);
    step(0, 0, 0, 0, 0);
    chk("inh_second_rise", seatbelt_cmd, 1'b1);
    idle_to(45, 0);
    chk_int("inh_edges", edges[0], 2);
    restart();
    inh_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) inh_r = !inh_r;
      step($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, inh_r,
           $urandom_range(0, 29) == 0, $urandom_range(0, 249) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
